// File: rtl/core6_debug_pkg.sv
// Shared types and constants for the six-core cross-halt debug sequencer.
package core6_debug_pkg;

    localparam int unsigned N_CORES_DEF = 6;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned SRC_W       = 3;
    localparam logic [SRC_W-1:0] HOST_SRC = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALTING  = 2'd1,
        ST_HALTED   = 2'd2,
        ST_RESUMING = 2'd3
    } state_e;

endpackage

// File: rtl/core6_debug_prio_enc.sv
// Lowest-index-wins priority encoder; reports the index of the first set request bit.
module core6_debug_prio_enc #(
    parameter int unsigned N     = 6,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c   = IDX_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core6_debug_halt_sequencer.sv
// Cross-halt sequencer: halts all enabled cores on any breakpoint/ack/host request
// and resumes them together, with a bounded acknowledge phase.
module core6_debug_halt_sequencer
    import core6_debug_pkg::*;
#(
    parameter int unsigned N_CORES        = N_CORES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_CORES-1:0] core_enable,
    input  logic [N_CORES-1:0] break_hit,
    input  logic [N_CORES-1:0] debugack,
    input  logic               host_halt_req,
    input  logic               host_resume_req,
    output logic [N_CORES-1:0] debugreq,
    output logic               all_halted,
    output logic [SRC_W-1:0]   halt_source,
    output logic               timeout_err,
    output logic [1:0]         state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [N_CORES-1:0] enable_q, enable_d;
    logic [N_CORES-1:0] debugreq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               all_halted_d;
    logic               timeout_err_d;
    logic [SRC_W-1:0]   halt_source_d;

    logic [N_CORES-1:0] core_evt;
    logic [SRC_W-1:0]   src_idx;
    logic               src_valid;
    logic               trigger;
    logic               acks_all;
    logic               acks_none;
    logic               phase_expired;

    assign core_evt      = (break_hit | debugack) & core_enable;
    assign trigger       = host_halt_req | (|core_evt);
    assign acks_all      = ((debugack & enable_q) == enable_q);
    assign acks_none     = ((debugack & enable_q) == '0);
    assign phase_expired = (cnt_q == CNT_LAST);

    core6_debug_prio_enc #(
        .N     (N_CORES),
        .IDX_W (SRC_W)
    ) u_prio_enc (
        .req     (core_evt),
        .idx_c   (src_idx),
        .valid_c (src_valid)
    );

    // Next-state and next-output logic; counter defaults to zero so every phase entry clears it.
    always_comb begin
        state_d       = state_q;
        enable_d      = enable_q;
        cnt_d         = '0;
        all_halted_d  = 1'b0;
        timeout_err_d = timeout_err;
        halt_source_d = halt_source;

        case (state_q)
            ST_RUN: begin
                if (trigger) begin
                    state_d       = ST_HALTING;
                    enable_d      = core_enable;
                    halt_source_d = src_valid ? src_idx : HOST_SRC;
                    timeout_err_d = 1'b0;
                end
            end
            ST_HALTING: begin
                if (acks_all) begin
                    state_d      = ST_HALTED;
                    all_halted_d = 1'b1;
                end else if (phase_expired) begin
                    state_d       = ST_HALTED;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HALTED: begin
                // Resume wins over any simultaneous halt request; halt sources are ignored here.
                if (host_resume_req) begin
                    state_d = ST_RESUMING;
                end else begin
                    all_halted_d = all_halted;
                end
            end
            ST_RESUMING: begin
                if (acks_none) begin
                    state_d = ST_RUN;
                end else if (phase_expired) begin
                    state_d       = ST_RUN;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        debugreq_d = ((state_d == ST_HALTING) || (state_d == ST_HALTED)) ? enable_d : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            enable_q    <= '0;
            cnt_q       <= '0;
            debugreq    <= '0;
            all_halted  <= 1'b0;
            halt_source <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            cnt_q       <= cnt_d;
            debugreq    <= debugreq_d;
            all_halted  <= all_halted_d;
            halt_source <= halt_source_d;
            timeout_err <= timeout_err_d;
        end
    end

    assign state = state_q;

endmodule
